// File: rtl/llki_pp_param.sv
// LLKI protocol processor: a TL-UL slave that collects one UDP-framed LLKI
// packet into a buffer, validates it (checksum, destination, length, command)
// and then drives the key-load or key-clear handshake towards a single core.
module llki_pp_param #(
  parameter logic [15:0] MY_ID          = 16'd0,
  parameter int          MAX_KEY_WORDS  = 8,
  parameter int          SRC_W          = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [31:0]      a_address,
  input  logic [7:0]       a_mask,
  input  logic [63:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic [63:0]      d_data,
  output logic             d_denied,
  output logic [63:0]      key_data,
  output logic             key_valid,
  input  logic             key_ready,
  input  logic             key_complete,
  output logic             clear_key,
  input  logic             clear_key_ack
);
  localparam int DEPTH = MAX_KEY_WORDS + 2;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_ACK  = 3'd0;
  localparam logic [2:0] OP_ACKD = 3'd1;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_CLEAR  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CHECK      = 3'd1;
  localparam logic [2:0] S_LOAD_ISSUE = 3'd2;
  localparam logic [2:0] S_LOAD_WAIT  = 3'd3;
  localparam logic [2:0] S_CLEAR_WAIT = 3'd4;

  logic [63:0]   buf_q [DEPTH];
  logic [PW-1:0] wrp, key_id, kidx;
  logic [31:0]   csum;
  logic [2:0]    state;
  logic          done, err, ovf, hdr_chk;
  logic [3:0]    err_code, chk_code;
  logic [TW-1:0] tmo;

  // Request decode. The mask carries no information for full 8-byte puts.
  logic        accept, legal, is_get, is_put, push_req, push_ok, push_drop, abort;
  logic [31:0] off;
  logic        unused_mask;
  assign unused_mask = ^a_mask;
  assign accept    = a_valid & a_ready;
  assign off       = a_address - BASE_ADDR;
  assign is_get    = (a_opcode == OP_GET);
  assign is_put    = (a_opcode == OP_PUTF);
  assign legal     = ((off == 32'h0) || (off == 32'h8)) && (a_size == 3'd3) && (is_get || is_put);
  assign push_req  = accept && legal && is_put && (off == 32'h0);
  assign abort     = accept && legal && is_put && (off == 32'h8);
  assign push_ok   = push_req && (state == S_IDLE) && (wrp != PW'(DEPTH));
  assign push_drop = push_req && !push_ok;

  // Header fields straight out of the buffer.
  logic [15:0] len, dst;
  logic [12:0] nw;
  logic [7:0]  cmd, ksz;
  logic        len_bad, pkt_done, key_last, tmo_hit;
  assign len      = buf_q[0][31:16];
  assign dst      = buf_q[0][47:32];
  assign nw       = len[15:3];
  assign cmd      = buf_q[1][63:56];
  assign ksz      = buf_q[1][55:48];
  assign len_bad  = (len[2:0] != 3'd0) || (nw < 13'd2) || (nw > 13'(DEPTH));
  assign pkt_done = (wrp >= PW'(2)) && (13'(wrp) == nw);
  assign key_last = (8'(key_id) == ksz - 8'd1);
  assign tmo_hit  = (tmo == TW'(TIMEOUT_CYCLES - 1));

  // One's-complement fold of the running 32-bit sum.
  logic [31:0] hsum;
  logic [16:0] f1;
  logic [15:0] fold;
  assign hsum = 32'(a_data[15:0]) + 32'(a_data[31:16]) + 32'(a_data[47:32]) + 32'(a_data[63:48]);
  assign f1   = 17'(csum[15:0]) + 17'(csum[31:16]);
  assign fold = f1[15:0] + 16'(f1[16]);

  // Packet validation: first failing rule wins.
  always_comb begin
    chk_code = 4'd0;
    if (fold != 16'hFFFF)                                  chk_code = 4'd1;
    else if (dst != MY_ID)                                 chk_code = 4'd2;
    else if (cmd == CMD_LOAD && (ksz == 8'd0 || 13'(ksz) != nw - 13'd2)) chk_code = 4'd3;
    else if (cmd != CMD_LOAD && cmd != CMD_CLEAR && cmd != CMD_STATUS)   chk_code = 4'd4;
  end

  logic [63:0] status;
  assign status = {44'd0, ovf, state, 8'(wrp), err_code, key_complete, key_ready, err, done};

  // Key words are presented continuously; the strobe is the single ISSUE cycle.
  assign kidx      = key_id + PW'(2);
  assign key_data  = buf_q[kidx];
  assign key_valid = (state == S_LOAD_ISSUE);

  // TL A/D handshake: single outstanding request, response held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ready  <= 1'b1;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_denied <= 1'b0;
    end else if (accept) begin
      a_ready  <= 1'b0;
      d_valid  <= 1'b1;
      d_opcode <= is_get ? OP_ACKD : OP_ACK;
      d_size   <= a_size;
      d_source <= a_source;
      d_data   <= (is_get && legal) ? status : '0;
      d_denied <= !legal;
    end else if (d_valid && d_ready) begin
      d_valid <= 1'b0;
      a_ready <= 1'b1;
    end
  end

  // Packet buffer, checksum, status flags and the protocol FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wrp       <= '0;
      csum      <= '0;
      state     <= S_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      ovf       <= 1'b0;
      hdr_chk   <= 1'b0;
      key_id    <= '0;
      tmo       <= '0;
      clear_key <= 1'b0;
    end else begin
      hdr_chk   <= 1'b0;
      clear_key <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        wrp      <= '0;
        csum     <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= '0;
        ovf      <= 1'b0;
      end else begin
        if (push_drop) ovf <= 1'b1;
        if (push_ok) begin
          buf_q[wrp] <= a_data;
          wrp        <= wrp + 1'b1;
          csum       <= ((wrp == '0) ? 32'd0 : csum) + hsum;
          hdr_chk    <= (wrp == '0);
          if (wrp == '0) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            ovf      <= 1'b0;
          end
        end
        case (state)
          S_IDLE: begin
            if (hdr_chk && len_bad) begin
              err_code <= 4'd3; err <= 1'b1; done <= 1'b1; wrp <= '0;
            end else if (pkt_done) begin
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (chk_code != 4'd0) begin
              err_code <= chk_code; err <= 1'b1; done <= 1'b1; wrp <= '0;
              state    <= S_IDLE;
            end else if (cmd == CMD_LOAD) begin
              key_id <= '0;
              state  <= S_LOAD_ISSUE;
            end else if (cmd == CMD_CLEAR) begin
              clear_key <= 1'b1;
              tmo       <= '0;
              state     <= S_CLEAR_WAIT;
            end else begin
              done  <= 1'b1; wrp <= '0;
              state <= S_IDLE;
            end
          end
          S_LOAD_ISSUE: begin
            tmo   <= '0;
            state <= S_LOAD_WAIT;
          end
          S_LOAD_WAIT: begin
            // tmo==0 marks the first wait cycle, where key_ready is not trusted.
            if (tmo != '0 && key_ready) begin
              if (key_last) begin
                done <= 1'b1; wrp <= '0; state <= S_IDLE;
              end else begin
                key_id <= key_id + 1'b1;
                state  <= S_LOAD_ISSUE;
              end
            end else if (tmo_hit) begin
              err_code <= 4'd6; err <= 1'b1; done <= 1'b1; wrp <= '0; state <= S_IDLE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_CLEAR_WAIT: begin
            if (clear_key_ack) begin
              done <= 1'b1; wrp <= '0; state <= S_IDLE;
            end else if (tmo_hit) begin
              err_code <= 4'd6; err <= 1'b1; done <= 1'b1; wrp <= '0; state <= S_IDLE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_llki_pp_param.sv
// Bench for llki_pp_param: packet-level model of the processor, a per-cycle
// compare process on the TL D channel and the key strobe, and literal checks
// of the STATUS word after each directed scenario.
module tb_llki_pp_param;
  localparam logic [15:0] MY_ID = 16'd0;
  localparam int          MAXW  = 8;
  localparam int          SRC_W = 8;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          TMO   = 64;
  localparam int          DEPTH = MAXW + 2;

  logic             clk = 1'b0, rst = 1'b1;
  logic             a_valid = 1'b0, a_ready;
  logic [2:0]       a_opcode = '0, a_size = '0;
  logic [SRC_W-1:0] a_source = '0;
  logic [31:0]      a_address = '0;
  logic [7:0]       a_mask = '0;
  logic [63:0]      a_data = '0;
  logic             d_valid, d_ready = 1'b1;
  logic [2:0]       d_opcode, d_size;
  logic [SRC_W-1:0] d_source;
  logic [63:0]      d_data, key_data;
  logic             d_denied, key_valid, clear_key;
  logic             key_ready = 1'b0, key_complete = 1'b0, clear_key_ack = 1'b0;

  always #5 clk = ~clk;

  llki_pp_param #(.MY_ID(MY_ID), .MAX_KEY_WORDS(MAXW), .SRC_W(SRC_W),
                  .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .key_complete(key_complete), .clear_key(clear_key), .clear_key_ack(clear_key_ack)
  );

  typedef struct {
    logic             denied;
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             chk_data;
    logic [63:0]      data;
  } rsp_t;

  rsp_t        exp_rsp[$];
  logic [63:0] exp_key[$];
  int          checks = 0, errors = 0, clear_cnt = 0, kv_cnt = 0, kr_cnt = 0;
  logic [63:0] last_rd = '0;
  bit          auto_kr = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- packet-level model ----------------
  logic [63:0] m_buf [DEPTH];
  int m_wrp = 0, m_code = 0, m_state = 0;
  bit m_done = 0, m_err = 0, m_ovf = 0, m_busy = 0;

  function automatic int fold16(input longint s);
    longint t = s;
    while (t > 65535) t = (t & 65535) + (t >> 16);
    return int'(t);
  endfunction

  function automatic longint halves(input logic [63:0] w);
    return longint'(w[15:0]) + longint'(w[31:16]) + longint'(w[47:32]) + longint'(w[63:48]);
  endfunction

  function automatic logic [63:0] m_status();
    logic [63:0] s = '0;
    s[0] = m_done; s[1] = m_err; s[2] = key_ready; s[3] = key_complete;
    s[7:4] = m_code[3:0]; s[15:8] = m_wrp[7:0]; s[18:16] = m_state[2:0]; s[19] = m_ovf;
    return s;
  endfunction

  task automatic m_fail(input int c);
    m_code = c; m_err = 1; m_done = 1; m_wrp = 0; m_busy = 0; m_state = 0;
  endtask

  task automatic m_ok();
    m_done = 1; m_wrp = 0; m_busy = 0; m_state = 0;
  endtask

  task automatic m_packet();
    longint s = 0;
    int nwd, cmd, ksz, code;
    for (int i = 0; i < m_wrp; i++) s += halves(m_buf[i]);
    nwd  = int'(m_buf[0][31:16]) / 8;
    cmd  = int'(m_buf[1][63:56]);
    ksz  = int'(m_buf[1][55:48]);
    code = 0;
    if (fold16(s) != 'hFFFF)                     code = 1;
    else if (m_buf[0][47:32] != MY_ID)           code = 2;
    else if (cmd == 1 && (ksz == 0 || ksz != nwd - 2)) code = 3;
    else if (cmd < 1 || cmd > 3)                 code = 4;
    if (code != 0) m_fail(code);
    else if (cmd == 1) begin
      for (int i = 0; i < (auto_kr ? ksz : 1); i++) exp_key.push_back(m_buf[2 + i]);
      if (auto_kr) m_ok();
      else begin m_busy = 1; m_state = 3; end
    end else if (cmd == 2) begin
      if (clear_key_ack) m_ok(); else m_fail(6);
    end else m_ok();
  endtask

  task automatic m_push(input logic [63:0] w);
    int len;
    if (m_busy || m_wrp == DEPTH) begin m_ovf = 1; return; end
    if (m_wrp == 0) begin m_done = 0; m_err = 0; m_code = 0; m_ovf = 0; end
    m_buf[m_wrp] = w;
    m_wrp++;
    len = int'(m_buf[0][31:16]);
    if (m_wrp == 1 && (len % 8 != 0 || len / 8 < 2 || len / 8 > DEPTH)) m_fail(3);
    else if (m_wrp >= 2 && m_wrp == len / 8) m_packet();
  endtask

  task automatic m_abort();
    m_wrp = 0; m_done = 0; m_err = 0; m_code = 0; m_ovf = 0; m_busy = 0; m_state = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    rsp_t r;
    if (!rst) begin
      if (d_valid) check("a_ready_during_d_valid", {63'd0, a_ready}, 64'd0);
      if (d_valid && d_ready) begin
        if (exp_rsp.size() == 0) check("d_valid_unexpected", {63'd0, d_valid}, 64'd0);
        else begin
          r = exp_rsp.pop_front();
          check("d_denied", {63'd0, d_denied}, {63'd0, r.denied});
          check("d_opcode", {61'd0, d_opcode}, {61'd0, r.opcode});
          check("d_size",   {61'd0, d_size},   {61'd0, r.size});
          check("d_source", 64'(d_source),     64'(r.source));
          if (r.chk_data) begin
            check("status", d_data, r.data);
            last_rd = d_data;
          end
        end
      end
      if (key_valid) begin
        kv_cnt++;
        if (exp_key.size() == 0) check("key_valid_unexpected", {63'd0, key_valid}, 64'd0);
        else check("key_data", key_data, exp_key.pop_front());
      end
      if (clear_key) clear_cnt++;
    end
  end

  // Core side: accept each key word three cycles after its strobe.
  always @(negedge clk) begin
    if (key_valid && auto_kr) begin kr_cnt = 3; key_ready = 1'b0; end
    else if (kr_cnt > 0) begin kr_cnt--; key_ready = (kr_cnt == 0); end
    else key_ready = 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic tl(input logic [2:0] op, input logic [31:0] addr, input logic [63:0] data,
                    input logic [2:0] size, input bit deny, input bit rd, input int hold);
    rsp_t r;
    int n = 0;
    r.denied = deny; r.opcode = (op == 3'd4) ? 3'd1 : 3'd0; r.size = size;
    r.source = SRC_W'($urandom); r.chk_data = rd && !deny; r.data = m_status();
    while (!a_ready && n < 100) begin @(negedge clk); n++; end
    if (!a_ready) check("a_ready_wait", {63'd0, a_ready}, 64'd1);
    exp_rsp.push_back(r);
    if (hold > 0) d_ready = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = data; a_size = size;
    a_source = r.source; a_mask = (op == 3'd1) ? 8'h0F : 8'hFF;
    @(negedge clk);
    a_valid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      check("d_valid_held", {63'd0, d_valid}, 64'd1);
      check("a_ready_low",  {63'd0, a_ready}, 64'd0);
      @(negedge clk);
    end
    d_ready = 1'b1;
    n = 0;
    while (exp_rsp.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_rsp.size() != 0) begin
      check("d_response_wait", 64'(exp_rsp.size()), 64'd0);
      exp_rsp.delete();
    end
  endtask

  task automatic push(input logic [63:0] w);
    m_push(w);
    tl(3'd0, BASE, w, 3'd3, 1'b0, 1'b0, 0);
  endtask

  task automatic rd_status();
    tl(3'd4, BASE, 64'd0, 3'd3, 1'b0, 1'b1, 0);
  endtask

  task automatic do_abort();
    tl(3'd0, BASE + 32'h8, 64'd0, 3'd3, 1'b0, 1'b0, 0);
    m_abort();
  endtask

  logic [63:0] pkt [DEPTH];

  task automatic mk(input logic [15:0] dst, input logic [15:0] len, input logic [7:0] cmd,
                    input logic [7:0] ksz, input int nw);
    longint s = 0;
    pkt[0] = {16'h00AA, dst, len, 16'h0000};
    pkt[1] = {cmd, ksz, 48'h0};
    for (int i = 2; i < nw; i++) pkt[i] = 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
    for (int i = 0; i < nw; i++) s += halves(pkt[i]);
    pkt[0][15:0] = ~16'(fold16(s));
  endtask

  task automatic send(input int nw);
    for (int i = 0; i < nw; i++) push(pkt[i]);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_a_ready",   {63'd0, a_ready},   64'd1);
    check("rst_d_valid",   {63'd0, d_valid},   64'd0);
    check("rst_key_valid", {63'd0, key_valid}, 64'd0);
    check("rst_clear_key", {63'd0, clear_key}, 64'd0);
    check("rst_key_data",  key_data,           64'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_status();
    check("status_after_reset", last_rd, 64'h0);

    // 1: good LoadKeyReq, two key words
    mk(16'd0, 16'd32, 8'h01, 8'd2, 4);
    send(4);
    repeat (30) @(negedge clk);
    rd_status();
    check("load_ok_status", last_rd, 64'h1);
    check("load_kv_count", 64'(kv_cnt), 64'd2);

    // 2: corrupted word -> checksum error
    mk(16'd0, 16'd32, 8'h01, 8'd2, 4);
    pkt[3][0] = ~pkt[3][0];
    send(4);
    repeat (10) @(negedge clk);
    rd_status();
    check("cksum_status", last_rd, 64'h13);
    check("cksum_kv_count", 64'(kv_cnt), 64'd2);

    // 3: wrong destination, then bad header length
    mk(16'd5, 16'd32, 8'h01, 8'd2, 4);
    send(4);
    repeat (10) @(negedge clk);
    rd_status();
    check("dst_status", last_rd, 64'h23);
    mk(16'd0, 16'h000C, 8'h01, 8'd2, 4);
    send(1);
    rd_status();
    check("len_status", last_rd, 64'h33);

    // Status command and unknown command
    mk(16'd0, 16'd16, 8'h03, 8'd0, 2);
    send(2);
    repeat (10) @(negedge clk);
    rd_status();
    check("statcmd_status", last_rd, 64'h1);
    mk(16'd0, 16'd16, 8'h7E, 8'd0, 2);
    send(2);
    repeat (10) @(negedge clk);
    rd_status();
    check("badcmd_status", last_rd, 64'h43);

    // 4: ClearKeyReq without ack -> timeout; then with ack
    mk(16'd0, 16'd16, 8'h02, 8'd0, 2);
    send(2);
    repeat (TMO + 20) @(negedge clk);
    rd_status();
    check("clear_tmo_status", last_rd, 64'h63);
    check("clear_pulses", 64'(clear_cnt), 64'd1);
    clear_key_ack = 1'b1;
    send(2);
    repeat (10) @(negedge clk);
    rd_status();
    check("clear_ack_status", last_rd, 64'h1);
    check("clear_pulses2", 64'(clear_cnt), 64'd2);
    clear_key_ack = 1'b0;

    // 5: push while waiting for key_ready, then ABORT
    auto_kr = 1'b0;
    mk(16'd0, 16'd32, 8'h01, 8'd2, 4);
    send(4);
    repeat (4) @(negedge clk);
    push(64'hFFFF_0000_FFFF_0000);
    rd_status();
    check("ovf_status", last_rd, 64'hB0400);
    do_abort();
    rd_status();
    check("abort_status", last_rd, 64'h0);
    repeat (TMO + 10) @(negedge clk);
    check("abort_kv_count", 64'(kv_cnt), 64'd3);
    auto_kr = 1'b1;

    // 6: denied accesses leave wrP alone; stalled D channel
    mk(16'd0, 16'd32, 8'h01, 8'd2, 4);
    send(1);
    tl(3'd1, BASE, 64'hDEAD_BEEF, 3'd3, 1'b1, 1'b0, 0);
    tl(3'd4, BASE + 32'h4, 64'd0, 3'd3, 1'b1, 1'b1, 0);
    tl(3'd4, BASE, 64'd0, 3'd2, 1'b1, 1'b1, 0);
    tl(3'd4, BASE + 32'h8, 64'd0, 3'd3, 1'b0, 1'b1, 5);
    check("denied_wrp_status", last_rd, 64'h100);
    do_abort();

    repeat (5) @(negedge clk);
    check("keys_pending", 64'(exp_key.size()), 64'd0);
    check("rsp_pending",  64'(exp_rsp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
